// File: rtl/key_debounce_bank.sv
// key_debounce_bank: N-channel key synchroniser/debouncer with press, release, long-press and repeat events.
// Optional build macro KEY_REPEAT_EN enables auto-repeat; without it KEY_REPEAT is tied to 0.
module key_debounce_bank #(
  parameter int N_KEYS     = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int FILT_CNT   = 16,
  parameter int LONG_CNT   = 1000,
  parameter int REPEAT_CNT = 200
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_DOWN,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_LONG,
  output logic [N_KEYS-1:0] KEY_REPEAT
);

  localparam int FC_W = $clog2(FILT_CNT + 1);
`ifdef KEY_REPEAT_EN
  localparam int HC_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
`else
  localparam int HC_MAX = LONG_CNT;
`endif
  localparam int HC_W = $clog2(HC_MAX + 1);

  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FILT_CNT - 1);
  localparam logic [HC_W-1:0] LONG_LAST = HC_W'(LONG_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CNT - 1);
`else
  localparam logic [HC_W-1:0] LONG_SAT  = HC_W'(LONG_CNT);
`endif

  typedef enum logic [1:0] {UP, FILT_DN, DOWN, FILT_UP} state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic            sync1, sync2, p;
    state_t          state, state_n;
    logic [FC_W-1:0] fc, fc_n;
    logic [HC_W-1:0] hc, hc_n;
    logic            long_flag, long_flag_n;
    logic            down_q, press_q, release_q, long_q;
    logic            down_n, press_n, release_n, long_n;
`ifdef KEY_REPEAT_EN
    logic            repeat_q, repeat_n;
`endif

    assign p = ACTIVE_LOW ? ~sync2 : sync2;

    // Synchroniser flops start at the released pin level so reset never looks like a press.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sync1     <= ACTIVE_LOW;
        sync2     <= ACTIVE_LOW;
        state     <= UP;
        fc        <= '0;
        hc        <= '0;
        long_flag <= 1'b0;
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_q  <= 1'b0;
`endif
      end else begin
        sync1     <= KEY_IN[i];
        sync2     <= sync1;
        state     <= state_n;
        fc        <= fc_n;
        hc        <= hc_n;
        long_flag <= long_flag_n;
        down_q    <= down_n;
        press_q   <= press_n;
        release_q <= release_n;
        long_q    <= long_n;
`ifdef KEY_REPEAT_EN
        repeat_q  <= repeat_n;
`endif
      end
    end

    always_comb begin
      state_n     = state;
      fc_n        = fc;
      hc_n        = hc;
      long_flag_n = long_flag;
      press_n     = 1'b0;
      release_n   = 1'b0;
      long_n      = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_n    = 1'b0;
`endif
      case (state)
        UP: begin
          if (p) begin
            state_n = FILT_DN;
            fc_n    = '0;
          end
        end
        FILT_DN: begin
          if (!p) begin
            state_n = UP;
            fc_n    = '0;
          end else if (TICK) begin
            if (fc == FC_LAST) begin
              state_n     = DOWN;
              fc_n        = '0;
              hc_n        = '0;
              long_flag_n = 1'b0;
              press_n     = 1'b1;
            end else begin
              fc_n = fc + 1'b1;
            end
          end
        end
        DOWN: begin
          if (!p) begin
            state_n = FILT_UP;
            fc_n    = '0;
          end else if (TICK) begin
`ifdef KEY_REPEAT_EN
            // hc is reused: first it times the long press, then each repeat interval.
            if (!long_flag) begin
              if (hc == LONG_LAST) begin
                long_n      = 1'b1;
                long_flag_n = 1'b1;
                hc_n        = '0;
              end else begin
                hc_n = hc + 1'b1;
              end
            end else if (hc == REP_LAST) begin
              repeat_n = 1'b1;
              hc_n     = '0;
            end else begin
              hc_n = hc + 1'b1;
            end
`else
            if (hc != LONG_SAT) begin
              hc_n = hc + 1'b1;
              if (hc == LONG_LAST && !long_flag) begin
                long_n      = 1'b1;
                long_flag_n = 1'b1;
              end
            end
`endif
          end
        end
        FILT_UP: begin
          if (p) begin
            state_n = DOWN;
            fc_n    = '0;
          end else if (TICK) begin
            if (fc == FC_LAST) begin
              state_n     = UP;
              fc_n        = '0;
              hc_n        = '0;
              long_flag_n = 1'b0;
              release_n   = 1'b1;
            end else begin
              fc_n = fc + 1'b1;
            end
          end
        end
        default: begin
          state_n     = UP;
          fc_n        = '0;
          hc_n        = '0;
          long_flag_n = 1'b0;
        end
      endcase
      down_n = (state_n == DOWN) || (state_n == FILT_UP);
    end

    assign KEY_DOWN[i]    = down_q;
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = release_q;
    assign KEY_LONG[i]    = long_q;
`ifdef KEY_REPEAT_EN
    assign KEY_REPEAT[i]  = repeat_q;
`else
    assign KEY_REPEAT[i]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Self-checking bench for key_debounce_bank: a tick-counting gesture model checked every cycle,
// plus directed scenarios with hand-computed latencies. Honours KEY_REPEAT_EN like the design.
module tb_key_debounce_bank;
  localparam int NK   = 4;
  localparam int FILT = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          TICK = 1'b1;
  logic [NK-1:0] KEY_IN = '1;
  logic [NK-1:0] KEY_DOWN, KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_REPEAT;

  int vectors = 0;
  int miscompares = 0;

  key_debounce_bank #(
    .N_KEYS(NK), .ACTIVE_LOW(1'b1), .FILT_CNT(FILT), .LONG_CNT(LONG), .REPEAT_CNT(REP)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .KEY_IN(KEY_IN),
    .KEY_DOWN(KEY_DOWN), .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG(KEY_LONG), .KEY_REPEAT(KEY_REPEAT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic val);
    KEY_IN[ch] = val;
  endtask

  // Model: a key changes level after FILT ticks of continuous disagreement; hold time is
  // total ticks spent pressed, long at LONG ticks, repeats every REP ticks beyond that.
  logic [NK-1:0] m_d1 = '1, m_d2 = '1, m_lvl = '0, m_div = '0;
  int            m_cnt[NK];
  int            m_held[NK];
  logic [NK-1:0] exp_down = '0, exp_press = '0, exp_rel = '0, exp_long = '0, exp_rep = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_d1 = '1; m_d2 = '1; m_lvl = '0; m_div = '0;
      for (int i = 0; i < NK; i++) begin m_cnt[i] = 0; m_held[i] = 0; end
      exp_down = '0; exp_press = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
    end else begin
      exp_press = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
      for (int i = 0; i < NK; i++) begin
        logic pr;
        pr = ~m_d2[i];
        if (!m_div[i]) begin
          if (pr != m_lvl[i]) begin
            m_div[i] = 1'b1;
            m_cnt[i] = 0;
          end else if (m_lvl[i] && TICK) begin
            m_held[i] = m_held[i] + 1;
            if (m_held[i] == LONG) exp_long[i] = 1'b1;
`ifdef KEY_REPEAT_EN
            else if (m_held[i] > LONG && (m_held[i] - LONG) % REP == 0) exp_rep[i] = 1'b1;
`endif
          end
        end else if (pr == m_lvl[i]) begin
          m_div[i] = 1'b0;
        end else if (TICK) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == FILT) begin
            m_lvl[i]  = ~m_lvl[i];
            m_div[i]  = 1'b0;
            m_held[i] = 0;
            if (m_lvl[i]) exp_press[i] = 1'b1;
            else          exp_rel[i]   = 1'b1;
          end
        end
      end
      exp_down = m_lvl;
      m_d2 = m_d1;
      m_d1 = KEY_IN;
    end
  end

  always @(negedge CLK) begin
    checkOutput("KEY_DOWN",    KEY_DOWN,    exp_down);
    checkOutput("KEY_PRESS",   KEY_PRESS,   exp_press);
    checkOutput("KEY_RELEASE", KEY_RELEASE, exp_rel);
    checkOutput("KEY_LONG",    KEY_LONG,    exp_long);
    checkOutput("KEY_REPEAT",  KEY_REPEAT,  exp_rep);
  end

  int cnt_press[NK], cnt_long[NK], cnt_rep[NK];
  initial for (int i = 0; i < NK; i++) begin cnt_press[i] = 0; cnt_long[i] = 0; cnt_rep[i] = 0; end
  always @(negedge CLK) begin
    for (int i = 0; i < NK; i++) begin
      if (KEY_PRESS[i])  cnt_press[i]++;
      if (KEY_LONG[i])   cnt_long[i]++;
      if (KEY_REPEAT[i]) cnt_rep[i]++;
    end
  end

  // Edges counted from the first rising edge after the pin change; -1 means no pulse in budget.
  task automatic measureLatency(input int ch, input bit rel, input bit slow,
                                output int lat, output int late_reps);
    lat = -1;
    late_reps = 0;
    for (int n = 0; n < 60; n++) begin
      TICK = slow ? ((n % 5) == 0) : 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      if (n >= 2 && KEY_REPEAT[ch]) late_reps++;
      if (rel ? KEY_RELEASE[ch] : KEY_PRESS[ch]) begin
        lat = n;
        break;
      end
    end
    TICK = 1'b1;
  endtask

  int lat, reps, snap_a, snap_b;
  int first_long, n_long, first_rep, n_rep;

  initial begin
    #1 RST = 1'b1;
    #3;
    checkOutput("reset_down",  KEY_DOWN,    0);
    checkOutput("reset_press", KEY_PRESS,   0);
    checkOutput("reset_long",  KEY_LONG,    0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);

    $display("[TB] clean press on key 0");
    applyStimulus(0, 1'b0);
    measureLatency(0, 1'b0, 1'b0, lat, reps);
    checkOutput("clean_press_latency", lat, 6);
    checkOutput("clean_press_vector", KEY_PRESS, 4'b0001);
    checkOutput("clean_press_down", KEY_DOWN, 4'b0001);

    $display("[TB] bounce on key 1");
    snap_a = cnt_press[1];
    applyStimulus(1, 1'b0);
    repeat (3) @(negedge CLK);
    applyStimulus(1, 1'b1);
    repeat (2) @(negedge CLK);
    applyStimulus(1, 1'b0);
    #1 checkOutput("bounce_no_early_press", cnt_press[1] - snap_a, 0);
    measureLatency(1, 1'b0, 1'b0, lat, reps);
    checkOutput("bounce_press_latency", lat, 6);

    $display("[TB] long press on key 2");
    applyStimulus(2, 1'b0);
    measureLatency(2, 1'b0, 1'b0, lat, reps);
    checkOutput("long_key_press_latency", lat, 6);
    first_long = -1; n_long = 0; first_rep = -1; n_rep = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (KEY_LONG[2])   begin n_long++; if (first_long < 0) first_long = j; end
      if (KEY_REPEAT[2]) begin n_rep++;  if (first_rep < 0)  first_rep = j;  end
    end
    checkOutput("long_offset", first_long, 10);
    checkOutput("long_count", n_long, 1);
`ifdef KEY_REPEAT_EN
    checkOutput("repeat_first_offset", first_rep, 13);
    checkOutput("repeat_count", n_rep, 6);
`else
    checkOutput("repeat_first_offset", first_rep, -1);
    checkOutput("repeat_count", n_rep, 0);
`endif
    applyStimulus(2, 1'b1);
    measureLatency(2, 1'b1, 1'b0, lat, reps);
    checkOutput("long_release_latency", lat, 6);
    checkOutput("repeat_after_release", reps, 0);
    #1;
    snap_a = cnt_long[2];
    snap_b = cnt_rep[2];
    repeat (20) @(negedge CLK);
    #1;
    checkOutput("long_quiet_after_release", cnt_long[2] - snap_a, 0);
    checkOutput("repeat_quiet_after_release", cnt_rep[2] - snap_b, 0);

    $display("[TB] slow tick press on key 0");
    applyStimulus(0, 1'b1);
    measureLatency(0, 1'b1, 1'b0, lat, reps);
    checkOutput("key0_release_latency", lat, 6);
    repeat (2) @(negedge CLK);
    applyStimulus(0, 1'b0);
    measureLatency(0, 1'b0, 1'b1, lat, reps);
    checkOutput("slow_tick_press_edge", lat, 20);

    $display("[TB] reset during filtering on key 3");
    applyStimulus(3, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checkOutput("midreset_down",    KEY_DOWN,    0);
    checkOutput("midreset_press",   KEY_PRESS,   0);
    checkOutput("midreset_release", KEY_RELEASE, 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    measureLatency(3, 1'b0, 1'b0, lat, reps);
    checkOutput("held_through_reset_latency", lat, 6);
    checkOutput("held_through_reset_down", KEY_DOWN, 4'b1011);

    repeat (5) @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
